// File: rtl/track_sequencer.sv
// Purpose : five-slot note track sequencer (IDLE/PLAY/REC) driving the note memory address and write enable.
// Latency : button edge -> state/addr change on the next clk edge; tick -> addr step on the next clk edge.
// Backpressure: none; tick and buttons are consumed every cycle, and the memory must accept we on any tick.
//
// Ports:
//   clk, reset  - system clock; synchronous active-low reset
//   tick        - one-cycle note-rate pulse from the player divider
//   btn[4:0]    - debounced slot buttons (level); rising edges select/stop slots
//   rec         - record switch (level)
//   addr        - registered memory address = slot base + offset
//   we          - combinational write enable (tick while recording)
//   slot        - registered active slot index 0..4
//   state       - 0 IDLE, 1 PLAY, 2 REC
//   mute        - high whenever not playing
//   done        - one-cycle pulse when a track ends by itself (end of track or slot full)
module track_sequencer #(
    parameter int ADDR_W   = 15,
    parameter int SLOT_LEN = 6000,
    parameter int LEN_W    = 13
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick,
    input  logic [4:0]        btn,
    input  logic              rec,
    output logic [ADDR_W-1:0] addr,
    output logic              we,
    output logic [2:0]        slot,
    output logic [1:0]        state,
    output logic              mute,
    output logic              done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_REC  = 2'd2
    } state_t;

    // Per-slot base addresses as constants so no multiplier sits in the address path.
    localparam logic [ADDR_W-1:0] BASE1 = ADDR_W'(SLOT_LEN);
    localparam logic [ADDR_W-1:0] BASE2 = ADDR_W'(2 * SLOT_LEN);
    localparam logic [ADDR_W-1:0] BASE3 = ADDR_W'(3 * SLOT_LEN);
    localparam logic [ADDR_W-1:0] BASE4 = ADDR_W'(4 * SLOT_LEN);
    localparam logic [LEN_W-1:0]  FULL  = LEN_W'(SLOT_LEN);

    state_t                  state_q, state_d;
    logic [2:0]              slot_q, slot_d;
    logic [LEN_W-1:0]        off_q, off_d;
    logic [4:0][LEN_W-1:0]   len_q, len_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic                    done_q, done_d;
    logic [4:0]              btn_q;

    logic [4:0]              btn_edge;
    logic                    edge_any;
    logic [2:0]              edge_idx;
    logic [LEN_W-1:0]        off_inc;
    logic                    stop_rec;

    function automatic logic [ADDR_W-1:0] base_of(input logic [2:0] s);
        case (s)
            3'd1:    base_of = BASE1;
            3'd2:    base_of = BASE2;
            3'd3:    base_of = BASE3;
            3'd4:    base_of = BASE4;
            default: base_of = '0;
        endcase
    endfunction

    assign btn_edge = btn & ~btn_q;
    assign off_inc  = off_q + LEN_W'(1);

    // Lowest-index edge wins; scanning downwards lets the lowest hit overwrite.
    always_comb begin
        edge_any = 1'b0;
        edge_idx = 3'd0;
        for (int i = 4; i >= 0; i--) begin
            if (btn_edge[i]) begin
                edge_any = 1'b1;
                edge_idx = 3'(i);
            end
        end
    end

    assign stop_rec = !rec || (edge_any && (edge_idx == slot_q));

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        off_d   = off_q;
        len_d   = len_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (edge_any) begin
                    if (rec) begin
                        slot_d          = edge_idx;
                        off_d           = '0;
                        len_d[edge_idx] = '0;
                        state_d         = ST_REC;
                    end else if (len_q[edge_idx] != '0) begin
                        slot_d  = edge_idx;
                        off_d   = '0;
                        state_d = ST_PLAY;
                    end
                end
            end

            ST_PLAY: begin
                // A button edge pre-empts a same-cycle tick.
                if (edge_any) begin
                    off_d = '0;
                    if (edge_idx == slot_q) begin
                        state_d = ST_IDLE;
                    end else if (len_q[edge_idx] != '0) begin
                        slot_d = edge_idx;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (tick) begin
                    // off+1 == len avoids the len-1 underflow; len is nonzero while playing.
                    if (off_inc == len_q[slot_q]) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                        off_d   = '0;
                    end else begin
                        off_d = off_inc;
                    end
                end
            end

            ST_REC: begin
                // A tick in the same cycle as a stop still writes and is counted.
                if (tick) begin
                    len_d[slot_q] = off_inc;
                    off_d         = off_inc;
                    if (off_inc == FULL) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                        off_d   = '0;
                    end
                end
                if (stop_rec) begin
                    state_d = ST_IDLE;
                    off_d   = '0;
                end
            end

            default: begin
                state_d = ST_IDLE;
                off_d   = '0;
            end
        endcase
    end

    assign addr_d = base_of(slot_d) + ADDR_W'(off_d);

    always_ff @(posedge clk) begin
        // btn_q tracks btn even in reset so a held button yields no edge on release.
        btn_q <= btn;
        if (!reset) begin
            state_q <= ST_IDLE;
            slot_q  <= 3'd0;
            off_q   <= '0;
            len_q   <= '0;
            addr_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            off_q   <= off_d;
            len_q   <= len_d;
            addr_q  <= addr_d;
            done_q  <= done_d;
        end
    end

    assign addr  = addr_q;
    assign slot  = slot_q;
    assign state = state_q;
    assign done  = done_q;
    assign mute  = (state_q != ST_PLAY);
    assign we    = tick && (state_q == ST_REC);

endmodule

// File: tb/tb_track_sequencer.sv
// Purpose : self-checking bench for track_sequencer; write addresses go through a scoreboard queue.
// Latency : n/a (bench).
// Backpressure: n/a (bench).
module tb_track_sequencer;

    logic        clk;
    logic        reset;
    logic        tick;
    logic [4:0]  btn;
    logic        rec;
    logic [14:0] addr;
    logic        we;
    logic [2:0]  slot;
    logic [1:0]  state;
    logic        mute;
    logic        done;

    int n_checks;
    int n_errors;
    int done_cnt;
    int exp_a;
    int sb[$];

    track_sequencer #(.ADDR_W(15), .SLOT_LEN(6000), .LEN_W(13)) dut (
        .clk   (clk),
        .reset (reset),
        .tick  (tick),
        .btn   (btn),
        .rec   (rec),
        .addr  (addr),
        .we    (we),
        .slot  (slot),
        .state (state),
        .mute  (mute),
        .done  (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Write monitor: every we must match the oldest expected write address.
    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
        if (we === 1'b1) begin
            if (sb.size() == 0) begin
                check("we_unexpected", 32'(we), 32'(0));
            end else begin
                exp_a = sb.pop_front();
                check("wr_addr", 32'(addr), 32'(exp_a));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input int i);
        btn[i] = 1'b1;
        cyc();
        btn[i] = 1'b0;
        cyc();
    endtask

    // push_addr < 0 means no write is expected for this tick.
    task automatic tick_pulse(input int push_addr);
        if (push_addr >= 0) sb.push_back(push_addr);
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        cyc();
    endtask

    task automatic chk_st(input string tag, input int st, input int sl, input int ad);
        check({tag, "_state"}, 32'(state), 32'(st));
        check({tag, "_slot"},  32'(slot),  32'(sl));
        check({tag, "_addr"},  32'(addr),  32'(ad));
    endtask

    int d0;

    initial begin
        n_checks = 0;
        n_errors = 0;
        done_cnt = 0;
        reset = 1'b0;
        tick  = 1'b0;
        rec   = 1'b0;
        btn   = 5'b00100;

        // Reset with btn[2] held; release must not produce a transition.
        repeat (3) cyc();
        chk_st("rst", 0, 0, 0);
        check("rst_mute", 32'(mute), 32'(1));
        check("rst_we",   32'(we),   32'(0));
        check("rst_done", 32'(done), 32'(0));
        reset = 1'b1;
        repeat (2) cyc();
        chk_st("rel", 0, 0, 0);
        check("rel_mute", 32'(mute), 32'(1));
        btn = 5'b0;
        cyc();

        // Record three words into slot 1.
        rec = 1'b1;
        press(1);
        chk_st("rec1", 2, 1, 6000);
        check("rec1_mute", 32'(mute), 32'(1));
        for (int k = 0; k < 3; k++) tick_pulse(6000 + k);
        check("rec1_addr3", 32'(addr), 32'(6003));
        rec = 1'b0;
        cyc();
        chk_st("rec1_stop", 0, 1, 6000);
        check("rec1_done", 32'(done_cnt), 32'(0));
        check("rec1_sb", 32'(sb.size()), 32'(0));

        // Play slot 1: ends on its own after three ticks.
        press(1);
        chk_st("play1", 1, 1, 6000);
        check("play1_mute", 32'(mute), 32'(0));
        tick_pulse(-1);
        check("play1_a1", 32'(addr), 32'(6001));
        tick_pulse(-1);
        check("play1_a2", 32'(addr), 32'(6002));
        d0 = done_cnt;
        tick_pulse(-1);
        chk_st("play1_end", 0, 1, 6000);
        check("play1_done", 32'(done_cnt - d0), 32'(1));

        // Empty slot ignored; stop by active button gives no done.
        press(2);
        check("empty_state", 32'(state), 32'(0));
        press(1);
        check("stop_play", 32'(state), 32'(1));
        d0 = done_cnt;
        press(1);
        check("stop_state", 32'(state), 32'(0));
        check("stop_nodone", 32'(done_cnt - d0), 32'(0));

        // Simultaneous edges: lowest index wins.
        rec = 1'b1;
        btn = 5'b01001;
        cyc();
        btn = 5'b0;
        cyc();
        chk_st("prio", 2, 0, 0);
        rec = 1'b0;
        cyc();
        check("prio_stop", 32'(state), 32'(0));
        press(0);
        check("prio_empty", 32'(state), 32'(0));

        // Record two words in slot 3; other-slot edge ignored while recording.
        rec = 1'b1;
        press(3);
        chk_st("rec3", 2, 3, 18000);
        tick_pulse(18000);
        press(1);
        chk_st("rec3_ign", 2, 3, 18001);
        tick_pulse(18001);
        rec = 1'b0;
        cyc();
        check("rec3_stop", 32'(state), 32'(0));

        // Play slot 1; same-cycle tick + edge on slot 3 restarts at slot 3 base.
        press(1);
        tick_pulse(-1);
        check("xfer_pre", 32'(addr), 32'(6001));
        tick = 1'b1;
        btn[3] = 1'b1;
        cyc();
        tick = 1'b0;
        btn = 5'b0;
        cyc();
        chk_st("xfer", 1, 3, 18000);
        tick_pulse(-1);
        check("xfer_a1", 32'(addr), 32'(18001));
        d0 = done_cnt;
        press(2);
        check("xfer_empty", 32'(state), 32'(0));
        check("xfer_nodone", 32'(done_cnt - d0), 32'(0));

        // Fill slot 4 with SLOT_LEN+2 ticks; only the first SLOT_LEN write.
        rec = 1'b1;
        press(4);
        chk_st("rec4", 2, 4, 24000);
        d0 = done_cnt;
        for (int k = 0; k < 6002; k++) tick_pulse(k < 6000 ? 24000 + k : -1);
        chk_st("rec4_full", 0, 4, 24000);
        check("rec4_done", 32'(done_cnt - d0), 32'(1));
        check("rec4_sb", 32'(sb.size()), 32'(0));
        rec = 1'b0;
        cyc();

        // Play slot 4 back: length must be 6000.
        press(4);
        for (int k = 0; k < 5999; k++) tick_pulse(-1);
        chk_st("play4_last", 1, 4, 29999);
        d0 = done_cnt;
        tick_pulse(-1);
        check("play4_end", 32'(state), 32'(0));
        check("play4_done", 32'(done_cnt - d0), 32'(1));

        // Reset mid-record empties every slot.
        rec = 1'b1;
        press(3);
        tick_pulse(18000);
        reset = 1'b0;
        repeat (2) cyc();
        reset = 1'b1;
        cyc();
        chk_st("mrst", 0, 0, 0);
        rec = 1'b0;
        press(3);
        check("mrst_s3", 32'(state), 32'(0));
        press(1);
        check("mrst_s1", 32'(state), 32'(0));
        press(4);
        check("mrst_s4", 32'(state), 32'(0));
        check("final_sb", 32'(sb.size()), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
